// File: rtl/gcd_check_sink.sv
// Response-checking sink: loads a table of expected responses, accepts responses
// over val/rdy (optionally LFSR-throttled) and reports pass/fail/timeout.
module gcd_check_sink #(
    parameter int unsigned p_nbits   = 16,
    parameter int unsigned p_nmsgs   = 4,
    parameter int unsigned p_stall   = 0,
    parameter logic [15:0] p_seed    = 16'hACE1,
    parameter int unsigned p_timeout = 1024
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        exp_wen,
    input  logic [((p_nmsgs > 1) ? $clog2(p_nmsgs) : 1)-1:0] exp_waddr,
    input  logic [p_nbits-1:0]                          exp_wdata,
    input  logic                                        start,
    input  logic                                        resp_val,
    output logic                                        resp_rdy,
    input  logic [p_nbits-1:0]                          resp_msg,
    output logic                                        done,
    output logic                                        pass,
    output logic                                        timed_out,
    output logic [$clog2(p_nmsgs+1)-1:0]                err_count,
    output logic [((p_nmsgs > 1) ? $clog2(p_nmsgs) : 1)-1:0] first_err_idx
);

    localparam int unsigned AW = (p_nmsgs > 1) ? $clog2(p_nmsgs) : 1;
    localparam int unsigned EW = $clog2(p_nmsgs + 1);
    localparam int unsigned WW = $clog2(p_timeout + 1);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    state_t              state;
    logic [AW-1:0]       idx;
    logic [WW-1:0]       watchdog;
    logic [15:0]         lfsr;
    logic [p_nbits-1:0]  exp_table [p_nmsgs];

    logic                accept;
    logic                hit;
    logic                waddr_ok;
    logic                lfsr_fb;
    logic                wd_expired;

    // Fibonacci LFSR, taps 16,14,13,11 in right-shift form
    assign lfsr_fb    = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign resp_rdy   = (state == RUN) && ((p_stall == 0) || lfsr[0]);
    assign accept     = resp_val && resp_rdy;
    assign hit        = (resp_msg == exp_table[idx]);
    assign waddr_ok   = (32'(exp_waddr) < p_nmsgs);
    assign wd_expired = ((32'(watchdog) + 32'd1) >= p_timeout);

    assign done      = (state == DONE) || (state == TIMEOUT);
    assign pass      = (state == DONE) && (err_count == '0);
    assign timed_out = (state == TIMEOUT);

    // Expected table deliberately has no reset so a test can be rerun without reloading
    always_ff @(posedge clk) begin
        if (state == LOAD && exp_wen && waddr_ok) begin
            exp_table[exp_waddr] <= exp_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= LOAD;
            idx           <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            watchdog      <= '0;
            lfsr          <= p_seed;
        end else begin
            case (state)
                LOAD: begin
                    if (start) begin
                        state    <= RUN;
                        watchdog <= '0;
                    end
                end
                RUN: begin
                    lfsr <= {lfsr_fb, lfsr[15:1]};
                    // An accept on the expiry cycle wins over the timeout
                    if (accept) begin
                        watchdog <= '0;
                        if (!hit) begin
                            err_count <= err_count + EW'(1);
                            if (err_count == '0) begin
                                first_err_idx <= idx;
                            end
                        end
                        if (idx == AW'(p_nmsgs - 1)) begin
                            state <= DONE;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end else if (wd_expired) begin
                        state <= TIMEOUT;
                    end else begin
                        watchdog <= watchdog + WW'(1);
                    end
                end
                DONE, TIMEOUT: begin
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule
